// File: rtl/axi_gran_ax_splitter_if.sv
// Ax channel bundle (id/addr/len/size/burst plus valid/ready handshake)
// shared by the upstream and downstream sides of the granular burst splitter.
interface axi_gran_ax_splitter_if #(
    parameter int unsigned AddrWidth = 32'd64,
    parameter int unsigned IdWidth   = 32'd1
);
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 valid;
    logic                 ready;

    modport master (output id, addr, len, size, burst, valid, input  ready);
    modport slave  (input  id, addr, len, size, burst, valid, output ready);
endinterface

// File: rtl/axi_gran_ax_splitter.sv
// Ax-channel burst splitter: cuts each burst into fragments bounded by a runtime
// length limit and, for INCR, an optional 2^BoundaryLog2-byte address boundary.
module axi_gran_ax_splitter #(
    parameter int unsigned AddrWidth    = 32'd64,
    parameter int unsigned IdWidth      = 32'd1,
    parameter int unsigned BoundaryLog2 = 32'd12
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          split_en_i,
    input  logic                          bound_en_i,
    input  logic [7:0]                    len_limit_i,
    axi_gran_ax_splitter_if.slave         ax_i,
    axi_gran_ax_splitter_if.master        ax_o,
    output logic                          ax_last_o,
    output logic [IdWidth-1:0]            alloc_id_o,
    output logic [7:0]                    alloc_len_o,
    output logic                          alloc_req_o,
    input  logic                          alloc_gnt_i,
    output logic                          busy_o
);
    localparam int unsigned FW = (BoundaryLog2 + 1 > 9) ? BoundaryLog2 + 1 : 9;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } chan_t;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e               state_q, state_d;
    chan_t                ax_q, ax_d, in_ax, cur_ax, out_ax;
    logic [8:0]           beats_q, beats_d;
    logic [FW-1:0]        beats_left, limit_beats, bound_bytes, btb, frag;
    logic [7:0]           frag_len;
    logic [AddrWidth-1:0] aligned_addr, next_addr;
    logic                 single;

    always_comb begin
        in_ax.id    = ax_i.id;
        in_ax.addr  = ax_i.addr;
        in_ax.len   = ax_i.len;
        in_ax.size  = ax_i.size;
        in_ax.burst = ax_i.burst;
    end

    // Fragment sizing for whichever burst is current (incoming in Idle, latched in Busy)
    always_comb begin
        cur_ax       = (state_q == BUSY) ? ax_q : in_ax;
        beats_left   = (state_q == BUSY) ? FW'(beats_q) : FW'(in_ax.len) + FW'(1);
        limit_beats  = split_en_i ? FW'(len_limit_i) + FW'(1) : FW'(9'd256);
        aligned_addr = cur_ax.addr & ~((AddrWidth'(1) << cur_ax.size) - AddrWidth'(1));
        // Measured from the size-aligned beat address so an unaligned first beat counts as one beat
        bound_bytes  = (FW'(1) << BoundaryLog2) - FW'(aligned_addr[BoundaryLog2-1:0]);
        btb          = bound_bytes >> cur_ax.size;
        frag         = beats_left;
        if (limit_beats < frag) frag = limit_beats;
        if (split_en_i && bound_en_i && cur_ax.burst == BURST_INCR && btb < frag) frag = btb;
        frag_len     = 8'(frag - FW'(1));
        next_addr    = (cur_ax.burst == BURST_INCR)
                       ? aligned_addr + (AddrWidth'(frag) << cur_ax.size)
                       : cur_ax.addr;
        single       = !split_en_i || in_ax.burst == BURST_WRAP || frag == beats_left;
    end

    always_comb begin
        state_d     = state_q;
        ax_d        = ax_q;
        beats_d     = beats_q;
        out_ax      = '0;
        ax_o.valid  = 1'b0;
        ax_last_o   = 1'b0;
        ax_i.ready  = 1'b0;
        alloc_req_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ax_i.valid && alloc_gnt_i) begin
                    out_ax     = in_ax;
                    ax_o.valid = 1'b1;
                    if (single) begin
                        ax_last_o   = 1'b1;
                        ax_i.ready  = ax_o.ready;
                        alloc_req_o = ax_o.ready;
                    end else begin
                        out_ax.len  = frag_len;
                        ax_i.ready  = 1'b1;
                        alloc_req_o = 1'b1;
                        state_d     = BUSY;
                        ax_d        = in_ax;
                        // Without a downstream handshake the first fragment is re-presented from Busy
                        if (ax_o.ready) begin
                            beats_d   = 9'(beats_left - frag);
                            ax_d.addr = next_addr;
                        end else begin
                            beats_d   = 9'(beats_left);
                        end
                    end
                end
            end
            BUSY: begin
                out_ax     = ax_q;
                out_ax.len = frag_len;
                ax_o.valid = 1'b1;
                ax_last_o  = (frag == beats_left);
                if (ax_o.ready) begin
                    if (frag == beats_left) begin
                        state_d = IDLE;
                    end else begin
                        beats_d   = 9'(beats_left - frag);
                        ax_d.addr = next_addr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ax_q    <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            ax_q    <= ax_d;
            beats_q <= beats_d;
        end
    end

    assign ax_o.id     = out_ax.id;
    assign ax_o.addr   = out_ax.addr;
    assign ax_o.len    = out_ax.len;
    assign ax_o.size   = out_ax.size;
    assign ax_o.burst  = out_ax.burst;
    assign alloc_id_o  = ax_i.id;
    assign alloc_len_o = ax_i.len;
    assign busy_o      = (state_q == BUSY);
endmodule

// File: tb/tb_axi_gran_ax_splitter.sv
// Scoreboard bench for axi_gran_ax_splitter: directed bursts push expected
// fragments/allocations; a negedge monitor pops and compares on each handshake.
module tb_axi_gran_ax_splitter;
    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        last;
    } frag_t;

    typedef struct packed {
        logic [3:0] id;
        logic [7:0] len;
    } alloc_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       split_en, bound_en, alloc_gnt;
    logic [7:0] len_limit;
    logic       ax_last, alloc_req, busy;
    logic [3:0] alloc_id;
    logic [7:0] alloc_len;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: driven by the test

    frag_t  exp_q[$];
    alloc_t alloc_q[$];

    axi_gran_ax_splitter_if #(.AddrWidth(64), .IdWidth(4)) up_if ();
    axi_gran_ax_splitter_if #(.AddrWidth(64), .IdWidth(4)) dn_if ();

    axi_gran_ax_splitter #(
        .AddrWidth   (64),
        .IdWidth     (4),
        .BoundaryLog2(12)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .split_en_i (split_en),
        .bound_en_i (bound_en),
        .len_limit_i(len_limit),
        .ax_i       (up_if),
        .ax_o       (dn_if),
        .ax_last_o  (ax_last),
        .alloc_id_o (alloc_id),
        .alloc_len_o(alloc_len),
        .alloc_req_o(alloc_req),
        .alloc_gnt_i(alloc_gnt),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) dn_if.ready = 1'b1;
            else if (ready_mode == 1) dn_if.ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endfunction

    function automatic void push_frag(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst, input logic last);
        frag_t f;
        f.id = id; f.addr = addr; f.len = len; f.size = size; f.burst = burst; f.last = last;
        exp_q.push_back(f);
    endfunction

    function automatic void push_alloc(input logic [3:0] id, input logic [7:0] len);
        alloc_t a;
        a.id = id; a.len = len;
        alloc_q.push_back(a);
    endfunction

    // Monitor: fragment and allocation scoreboard plus stall-stability check
    initial begin
        frag_t  act, prev, exp;
        alloc_t aact, aexp;
        logic   prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                act = {dn_if.id, dn_if.addr, dn_if.len, dn_if.size, dn_if.burst, ax_last};
                if (prev_stall) begin
                    checks++;
                    if (!dn_if.valid || act !== prev) begin
                        errors++;
                        $display("FAIL stall_stable: actual valid=%0b %0h required valid=1 %0h", dn_if.valid, act, prev);
                    end
                end
                if (dn_if.valid && dn_if.ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL fragment: actual %0h required none", act);
                    end else begin
                        exp = exp_q.pop_front();
                        if (act !== exp) begin
                            errors++;
                            $display("FAIL fragment: actual id=%0h addr=%0h len=%0d last=%0b required id=%0h addr=%0h len=%0d last=%0b",
                                     act.id, act.addr, act.len, act.last, exp.id, exp.addr, exp.len, exp.last);
                        end
                    end
                end
                if (alloc_req) begin
                    aact = {alloc_id, alloc_len};
                    checks++;
                    if (alloc_q.size() == 0) begin
                        errors++;
                        $display("FAIL alloc: actual id=%0h len=%0d required none", aact.id, aact.len);
                    end else begin
                        aexp = alloc_q.pop_front();
                        if (aact !== aexp) begin
                            errors++;
                            $display("FAIL alloc: actual id=%0h len=%0d required id=%0h len=%0d",
                                     aact.id, aact.len, aexp.id, aexp.len);
                        end
                    end
                end
                prev_stall = dn_if.valid && !dn_if.ready;
                prev = act;
            end
        end
    end

    task automatic present(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        up_if.id = id; up_if.addr = addr; up_if.len = len; up_if.size = size; up_if.burst = burst;
        up_if.valid = 1'b1;
    endtask

    task automatic wait_accept();
        bit got = 0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (up_if.ready) got = 1;
        end
        check("accept_timeout", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        up_if.valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && alloc_q.size() == 0) done = 1;
        end
        check("drain_timeout", 64'(done), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        up_if.id = '0; up_if.addr = '0; up_if.len = '0; up_if.size = '0; up_if.burst = '0;
        up_if.valid = 1'b0;
        dn_if.ready = 1'b1;
        split_en = 1'b1; bound_en = 1'b0; len_limit = 8'd3; alloc_gnt = 1'b1;
        #12;
        check("rst_valid", 64'(dn_if.valid), 64'd0);
        check("rst_ready", 64'(up_if.ready), 64'd0);
        check("rst_alloc", 64'(alloc_req), 64'd0);
        check("rst_last", 64'(ax_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr", dn_if.addr, 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // INCR 16 beats, limit 4 beats, no boundary
        push_frag(4'h1, 64'h0, 8'd3, 3'd3, 2'b01, 1'b0);
        push_frag(4'h1, 64'h20, 8'd3, 3'd3, 2'b01, 1'b0);
        push_frag(4'h1, 64'h40, 8'd3, 3'd3, 2'b01, 1'b0);
        push_frag(4'h1, 64'h60, 8'd3, 3'd3, 2'b01, 1'b1);
        push_alloc(4'h1, 8'd15);
        present(4'h1, 64'h0, 8'd15, 3'd3, 2'b01);
        wait_accept();
        wait_drain();

        // INCR crossing 4 KiB
        bound_en = 1'b1; len_limit = 8'd255;
        push_frag(4'h2, 64'hFF0, 8'd1, 3'd3, 2'b01, 1'b0);
        push_frag(4'h2, 64'h1000, 8'd5, 3'd3, 2'b01, 1'b1);
        push_alloc(4'h2, 8'd7);
        present(4'h2, 64'hFF0, 8'd7, 3'd3, 2'b01);
        wait_accept();
        wait_drain();

        // Unaligned INCR, one beat per fragment
        len_limit = 8'd0;
        push_frag(4'h3, 64'h1003, 8'd0, 3'd2, 2'b01, 1'b0);
        push_frag(4'h3, 64'h1004, 8'd0, 3'd2, 2'b01, 1'b0);
        push_frag(4'h3, 64'h1008, 8'd0, 3'd2, 2'b01, 1'b1);
        push_alloc(4'h3, 8'd2);
        present(4'h3, 64'h1003, 8'd2, 3'd2, 2'b01);
        wait_accept();
        wait_drain();

        // WRAP never split; zero-cycle pass-through
        len_limit = 8'd1;
        push_frag(4'h4, 64'h80, 8'd7, 3'd2, 2'b10, 1'b1);
        push_alloc(4'h4, 8'd7);
        present(4'h4, 64'h80, 8'd7, 3'd2, 2'b10);
        #1;
        check("wrap_passthru_addr", dn_if.addr, 64'h80);
        check("wrap_passthru_len", 64'(dn_if.len), 64'd7);
        check("wrap_passthru_last", 64'({dn_if.valid, ax_last}), 64'd3);
        wait_accept();
        wait_drain();

        // Bypass
        split_en = 1'b0; len_limit = 8'd0;
        push_frag(4'h5, 64'hFF0, 8'd7, 3'd3, 2'b01, 1'b1);
        push_alloc(4'h5, 8'd7);
        present(4'h5, 64'hFF0, 8'd7, 3'd3, 2'b01);
        #1;
        check("bypass_passthru_len", 64'(dn_if.len), 64'd7);
        wait_accept();
        wait_drain();

        // FIXED with grant stall then random downstream stalls
        split_en = 1'b1; len_limit = 8'd3; alloc_gnt = 1'b0;
        present(4'h6, 64'h40, 8'd9, 3'd2, 2'b00);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("gnt_block_ready", 64'(up_if.ready), 64'd0);
            check("gnt_block_valid", 64'(dn_if.valid), 64'd0);
        end
        @(posedge clk); #1;
        push_frag(4'h6, 64'h40, 8'd3, 3'd2, 2'b00, 1'b0);
        push_frag(4'h6, 64'h40, 8'd3, 3'd2, 2'b00, 1'b0);
        push_frag(4'h6, 64'h40, 8'd1, 3'd2, 2'b00, 1'b1);
        push_alloc(4'h6, 8'd9);
        ready_mode = 1;
        alloc_gnt = 1'b1;
        wait_accept();
        wait_drain();

        // Reset during Busy after the first of four fragments
        ready_mode = 2; dn_if.ready = 1'b1; bound_en = 1'b0;
        push_frag(4'h7, 64'h0, 8'd3, 3'd3, 2'b01, 1'b0);
        push_alloc(4'h7, 8'd15);
        present(4'h7, 64'h0, 8'd15, 3'd3, 2'b01);
        wait_accept();
        dn_if.ready = 1'b0;
        @(negedge clk);
        check("busy_mid_burst", 64'(busy), 64'd1);
        #2; rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(dn_if.valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_last", 64'(ax_last), 64'd0);
        check("rst_mid_addr", dn_if.addr, 64'd0);
        check("rst_mid_queue", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // Fresh burst after reset
        ready_mode = 0;
        len_limit = 8'd1;
        push_frag(4'h8, 64'h100, 8'd1, 3'd2, 2'b01, 1'b0);
        push_frag(4'h8, 64'h108, 8'd1, 3'd2, 2'b01, 1'b1);
        push_alloc(4'h8, 8'd3);
        present(4'h8, 64'h100, 8'd3, 3'd2, 2'b01);
        wait_accept();
        wait_drain();

        repeat (3) @(negedge clk);
        check("final_frag_queue", 64'(exp_q.size()), 64'd0);
        check("final_alloc_queue", 64'(alloc_q.size()), 64'd0);
        check("final_busy", 64'(busy), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
